// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Sequences the PC, reads words from instruction memory over req/ack and
// buffers them in a 2-entry FIFO presented to the decoder via valid/ready.
// A halt from the decoder stops fetch until the next reset.
// Optional feature macro: FAVOR_FETCH_REDIRECT_EN (adds i_redirect/i_redirect_pc).
// All outputs come straight from registers.

module fetch_unit #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_data,
  output logic [31:0]       o_insn,
  output logic [ADDR_W-1:0] o_insn_pc,
  output logic              o_insn_valid,
  input  logic              i_insn_ready,
`ifdef FAVOR_FETCH_REDIRECT_EN
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
`endif
  input  logic              i_halt,
  output logic              o_halted
);

  // Word shown to the decoder when nothing is buffered; its kind field is
  // illegal so a stray decode is rejected, and it is never the halt word.
  localparam logic [31:0]       IDLE_INSN = 32'hFFFF_FFFF;
  localparam logic [ADDR_W-1:0] IDLE_PC   = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(32'd4);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  // Architectural state
  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [1:0]          r_cnt;
  logic [31:0]         r_head_data;   // FIFO head doubles as o_insn
  logic [ADDR_W-1:0]   r_head_pc;
  logic [31:0]         r_tail_data;
  logic [ADDR_W-1:0]   r_tail_pc;
  logic                r_valid;
  logic                r_mem_req;
  logic                r_halted;

  // Next-state values
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [1:0]          w_cnt_nxt;
  logic [31:0]         w_head_data_nxt;
  logic [ADDR_W-1:0]   w_head_pc_nxt;
  logic [31:0]         w_tail_data_nxt;
  logic [ADDR_W-1:0]   w_tail_pc_nxt;

  logic                w_ack;
  logic                w_pop;
  logic                w_redirect;
  logic [ADDR_W-1:0]   w_redirect_pc;

  // An ack only counts against a live request; r_mem_req already implies RUN
  // and free FIFO space, so a misbehaving memory cannot overfill the FIFO.
  assign w_ack = i_mem_ack && r_mem_req;
  assign w_pop = r_valid && i_insn_ready;

`ifdef FAVOR_FETCH_REDIRECT_EN
  assign w_redirect    = i_redirect;
  assign w_redirect_pc = i_redirect_pc & ~ADDR_W'(32'd3);
`else
  assign w_redirect    = 1'b0;
  assign w_redirect_pc = IDLE_PC;
`endif

  // Next-state decode: halt beats redirect beats ack/pop; HALTED holds.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_cnt_nxt       = r_cnt;
    w_head_data_nxt = r_head_data;
    w_head_pc_nxt   = r_head_pc;
    w_tail_data_nxt = r_tail_data;
    w_tail_pc_nxt   = r_tail_pc;

    case (r_state)
      ST_RUN: begin
        if (i_halt) begin
          // Flush and freeze; a same-cycle ack is dropped.
          w_state_nxt     = ST_HALTED;
          w_cnt_nxt       = 2'd0;
          w_head_data_nxt = IDLE_INSN;
          w_head_pc_nxt   = IDLE_PC;
        end else if (w_redirect) begin
          // Flush and restart at the aligned target; a same-cycle ack is dropped.
          w_pc_nxt        = w_redirect_pc;
          w_cnt_nxt       = 2'd0;
          w_head_data_nxt = IDLE_INSN;
          w_head_pc_nxt   = IDLE_PC;
        end else begin
          if (w_ack) begin
            w_pc_nxt = r_pc + PC_STEP;
          end else begin
            w_pc_nxt = r_pc;
          end
          case ({w_ack, w_pop})
            2'b10: begin
              case (r_cnt)
                2'd0: begin
                  w_head_data_nxt = i_mem_data;
                  w_head_pc_nxt   = r_pc;
                  w_cnt_nxt       = 2'd1;
                end
                2'd1: begin
                  w_tail_data_nxt = i_mem_data;
                  w_tail_pc_nxt   = r_pc;
                  w_cnt_nxt       = 2'd2;
                end
                default: w_cnt_nxt = r_cnt;
              endcase
            end
            2'b01: begin
              case (r_cnt)
                2'd1: begin
                  w_head_data_nxt = IDLE_INSN;
                  w_head_pc_nxt   = IDLE_PC;
                  w_cnt_nxt       = 2'd0;
                end
                2'd2: begin
                  w_head_data_nxt = r_tail_data;
                  w_head_pc_nxt   = r_tail_pc;
                  w_cnt_nxt       = 2'd1;
                end
                default: w_cnt_nxt = r_cnt;
              endcase
            end
            2'b11: begin
              case (r_cnt)
                2'd1: begin
                  w_head_data_nxt = i_mem_data;
                  w_head_pc_nxt   = r_pc;
                end
                2'd2: begin
                  w_head_data_nxt = r_tail_data;
                  w_head_pc_nxt   = r_tail_pc;
                  w_tail_data_nxt = i_mem_data;
                  w_tail_pc_nxt   = r_pc;
                end
                default: w_cnt_nxt = r_cnt;
              endcase
            end
            default: w_cnt_nxt = r_cnt;
          endcase
        end
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        // Unreachable encoding: fail safe into HALTED with an empty FIFO.
        w_state_nxt     = ST_HALTED;
        w_cnt_nxt       = 2'd0;
        w_head_data_nxt = IDLE_INSN;
        w_head_pc_nxt   = IDLE_PC;
      end
    endcase
  end

  // State and registered outputs; synchronous active-low reset drops any ack.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_RUN;
      r_pc        <= RESET_PC;
      r_cnt       <= 2'd0;
      r_head_data <= IDLE_INSN;
      r_head_pc   <= IDLE_PC;
      r_tail_data <= IDLE_INSN;
      r_tail_pc   <= IDLE_PC;
      r_valid     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_head_data <= w_head_data_nxt;
      r_head_pc   <= w_head_pc_nxt;
      r_tail_data <= w_tail_data_nxt;
      r_tail_pc   <= w_tail_pc_nxt;
      r_valid     <= (w_cnt_nxt != 2'd0);
      r_mem_req   <= (w_state_nxt == ST_RUN) && (w_cnt_nxt != 2'd2);
      r_halted    <= (w_state_nxt == ST_HALTED);
    end
  end

  assign o_mem_req    = r_mem_req;
  assign o_mem_addr   = r_pc;
  assign o_insn       = r_head_data;
  assign o_insn_pc    = r_head_pc;
  assign o_insn_valid = r_valid;
  assign o_halted     = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// Main instance: ADDR_W=32, RESET_PC=0x100. Second instance: ADDR_W=8,
// RESET_PC=0xFC for address wrap. Redirect case built with FAVOR_FETCH_REDIRECT_EN.

module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        mem_ack;
  logic        ready;
  logic        halt;
  logic        use_addr;
  logic [31:0] drv_data;
  logic [31:0] mem_data;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        insn_valid;
  logic        halted;

  logic        w8_ack;
  logic        w8_ready;
  logic        w8_halt;
  logic        w8_req;
  logic [7:0]  w8_addr;
  logic [31:0] w8_data;
  logic [31:0] w8_insn;
  logic [7:0]  w8_insn_pc;
  logic        w8_valid;
  logic        w8_halted;

`ifdef FAVOR_FETCH_REDIRECT_EN
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        w8_redirect;
  logic [7:0]  w8_redirect_pc;
`endif

  int n_tests;
  int n_fail;

  // Memory returns either the request address or a driven word.
  assign mem_data = use_addr ? mem_addr : drv_data;
  assign w8_data  = {24'h00_0000, w8_addr};

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0100)) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .o_mem_req    (mem_req),
    .o_mem_addr   (mem_addr),
    .i_mem_ack    (mem_ack),
    .i_mem_data   (mem_data),
    .o_insn       (insn),
    .o_insn_pc    (insn_pc),
    .o_insn_valid (insn_valid),
    .i_insn_ready (ready),
`ifdef FAVOR_FETCH_REDIRECT_EN
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
`endif
    .i_halt       (halt),
    .o_halted     (halted)
  );

  fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFC)) u_dut8 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .o_mem_req    (w8_req),
    .o_mem_addr   (w8_addr),
    .i_mem_ack    (w8_ack),
    .i_mem_data   (w8_data),
    .o_insn       (w8_insn),
    .o_insn_pc    (w8_insn_pc),
    .o_insn_valid (w8_valid),
    .i_insn_ready (w8_ready),
`ifdef FAVOR_FETCH_REDIRECT_EN
    .i_redirect   (w8_redirect),
    .i_redirect_pc(w8_redirect_pc),
`endif
    .i_halt       (w8_halt),
    .o_halted     (w8_halted)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed stimulus sequence.
  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    mem_ack  = 1'b0;
    ready    = 1'b0;
    halt     = 1'b0;
    use_addr = 1'b1;
    drv_data = 32'h0000_0000;
    w8_ack   = 1'b0;
    w8_ready = 1'b1;
    w8_halt  = 1'b0;
`ifdef FAVOR_FETCH_REDIRECT_EN
    redirect       = 1'b0;
    redirect_pc    = 32'h0000_0000;
    w8_redirect    = 1'b0;
    w8_redirect_pc = 8'h00;
`endif

    // Reset, with an ack presented during reset that must be dropped.
    step();
    mem_ack = 1'b1;
    step();
    check("rst_req",    {63'd0, mem_req},    64'd0);
    check("rst_addr",   {32'd0, mem_addr},   64'h100);
    check("rst_insn",   {32'd0, insn},       64'hFFFF_FFFF);
    check("rst_insnpc", {32'd0, insn_pc},    64'd0);
    check("rst_valid",  {63'd0, insn_valid}, 64'd0);
    check("rst_halted", {63'd0, halted},     64'd0);

    // First request appears after reset is released.
    rst_n   = 1'b1;
    mem_ack = 1'b0;
    step();
    check("first_req",  {63'd0, mem_req},  64'd1);
    check("first_addr", {32'd0, mem_addr}, 64'h100);
    check("w8_first_addr", {56'd0, w8_addr}, 64'hFC);

    // Streaming: ack and ready every cycle, one word per cycle.
    mem_ack = 1'b1;
    ready   = 1'b1;
    w8_ack  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("stream_valid", {63'd0, insn_valid}, 64'd1);
      check("stream_pc",    {32'd0, insn_pc},    64'h100 + 64'(4 * k));
      check("stream_insn",  {32'd0, insn},       64'h100 + 64'(4 * k));
      if (k == 0) begin
        check("wrap_pc0",   {56'd0, w8_insn_pc}, 64'hFC);
        check("wrap_addr1", {56'd0, w8_addr},    64'h00);
      end
      if (k == 1) begin
        check("wrap_pc1",   {56'd0, w8_insn_pc}, 64'h00);
        check("wrap_insn1", {32'd0, w8_insn},    64'h00);
      end
    end

    // Backpressure: FIFO fills, request drops; stray acks are ignored.
    ready = 1'b0;
    step();
    check("bp_req_drop", {63'd0, mem_req}, 64'd0);
    check("bp_head",     {32'd0, insn_pc}, 64'h10C);
    for (int k = 0; k < 4; k++) begin
      step();
      check("bp_req_low", {63'd0, mem_req},  64'd0);
      check("bp_addr",    {32'd0, mem_addr}, 64'h114);
      check("bp_hold",    {32'd0, insn_pc},  64'h10C);
    end
    ready   = 1'b1;
    mem_ack = 1'b0;
    step();
    check("bp_pop1_pc",  {32'd0, insn_pc}, 64'h110);
    check("bp_pop1_req", {63'd0, mem_req}, 64'd1);
    step();
    check("bp_empty_valid", {63'd0, insn_valid}, 64'd0);
    check("bp_empty_insn",  {32'd0, insn},       64'hFFFF_FFFF);
    check("bp_empty_pc",    {32'd0, insn_pc},    64'd0);

    // Slow memory: address held for all four request cycles.
    for (int k = 0; k < 3; k++) begin
      check("slow_req",  {63'd0, mem_req},  64'd1);
      check("slow_addr", {32'd0, mem_addr}, 64'h114);
      step();
    end
    check("slow_addr4", {32'd0, mem_addr}, 64'h114);
    use_addr = 1'b0;
    drv_data = 32'hDEAD_BEEF;
    mem_ack  = 1'b1;
    step();
    check("slow_insn",  {32'd0, insn},       64'hDEAD_BEEF);
    check("slow_pc",    {32'd0, insn_pc},    64'h114);
    check("slow_valid", {63'd0, insn_valid}, 64'd1);

    // Halt pulse together with an ack.
    use_addr = 1'b1;
    ready    = 1'b0;
    halt     = 1'b1;
    step();
    halt  = 1'b0;
    ready = 1'b1;
    check("halt_halted", {63'd0, halted},     64'd1);
    check("halt_valid",  {63'd0, insn_valid}, 64'd0);
    check("halt_insn",   {32'd0, insn},       64'hFFFF_FFFF);
    check("halt_req",    {63'd0, mem_req},    64'd0);
    for (int k = 0; k < 20; k++) begin
      step();
      check("halt_no_req", {63'd0, mem_req}, 64'd0);
    end
    check("halt_stay",   {63'd0, halted},   64'd1);
    check("halt_pc_frz", {32'd0, mem_addr}, 64'h118);

    // Reset leaves HALTED.
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    step();
    check("rst2_halted", {63'd0, halted},   64'd0);
    check("rst2_addr",   {32'd0, mem_addr}, 64'h100);
    rst_n = 1'b1;
    step();
    check("rst2_req", {63'd0, mem_req}, 64'd1);

`ifdef FAVOR_FETCH_REDIRECT_EN
    // Redirect with a full FIFO and an ack present.
    ready   = 1'b0;
    mem_ack = 1'b1;
    step();
    step();
    check("redir_full", {63'd0, mem_req}, 64'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0203;
    step();
    redirect = 1'b0;
    mem_ack  = 1'b0;
    check("redir_valid", {63'd0, insn_valid}, 64'd0);
    check("redir_req",   {63'd0, mem_req},    64'd1);
    check("redir_addr",  {32'd0, mem_addr},   64'h200);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the decoder. It sequences the program counter, reads 32-bit instruction words from instruction memory over a req/ack handshake, and buffers them in a 2-entry FIFO. It presents them to the decoder with a valid/ready handshake. It stops permanently when the decoder signals halt.

## Interface
- `ADDR_W`, 32: PC and memory address width in bits (byte address).
- `RESET_PC`, 0: PC loaded on reset; low 2 bits must be 0.
- `i_clk` in 1: clock; all logic on rising edge.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `o_mem_req` in/out: out 1: memory read request.
- `o_mem_addr` out `ADDR_W`: read address; stable while `o_mem_req` is high and `i_mem_ack` is low.
- `i_mem_ack` in 1: memory completes the request this cycle; only meaningful while `o_mem_req` is high.
- `i_mem_data` in 32: instruction word; valid when `i_mem_ack` is high.
- `o_insn` out 32: head-of-FIFO instruction, to decoder `i_insn`.
- `o_insn_pc` out `ADDR_W`: address of `o_insn`.
- `o_insn_valid` out 1: `o_insn` holds a fetched word.
- `i_insn_ready` in 1: downstream consumes the head word this cycle when valid.
- `i_halt` in 1: from decoder `o_halt`; level or pulse.
- `o_halted` out 1: fetch has stopped.
- `i_redirect` in 1: present only with `FAVOR_FETCH_REDIRECT_EN`.
- `i_redirect_pc` in `ADDR_W`: present only with `FAVOR_FETCH_REDIRECT_EN`.

## Operation
- **States:**
  - RUN:
    - PC register `pc` holds the next fetch address.
    - FIFO count `cnt` is 0..2.
  - HALTED: terminal until reset.
- **Request:** `o_mem_req = (state==RUN) && (cnt<2)`; `o_mem_addr = pc`.
  - At most one request is outstanding; the word returns in the ack cycle.
- **Ack in RUN:**
  - Push `{i_mem_data, pc}` into the FIFO.
  - `pc <= pc + 4`, wrapping modulo 2^`ADDR_W`.
- **Pop:** occurs when `o_insn_valid && i_insn_ready`.
  - Push and pop in the same cycle leave `cnt` unchanged; order is preserved.
- **Idle output value:**
  - When `cnt==0`, `o_insn = 32'hFFFF_FFFF` (kind field bits 30:29 = 11, which the decoder rejects, never the halt word 0).
  - `o_insn_pc = 0`.
- **`i_halt` high in RUN:**
  - Next state is HALTED.
  - FIFO flushed (`cnt<=0`); an ack in the same cycle is discarded; `pc` frozen.
  - In HALTED: `o_mem_req=0`, `o_insn_valid=0`, `o_halted=1`. Later `i_halt`, ack and ready inputs are ignored.
- **Memory misbehaviour:** `i_mem_ack` while `o_mem_req` is low is ignored.
- **Reset:**
  - Takes effect from any state, including mid-request.
  - `pc<=RESET_PC`, `cnt<=0`, state RUN.
  - An ack in the reset cycle is dropped.

## Timing
- **Reset values:** `o_mem_req=0`, `o_mem_addr=RESET_PC`, `o_insn=32'hFFFF_FFFF`, `o_insn_pc=0`, `o_insn_valid=0`, `o_halted=0`.
- **First request:** `o_mem_req` rises in the first cycle after `i_rst_n` is sampled high.
- **Latency:**
  - Ack in cycle N → word visible with `o_insn_valid=1` in cycle N+1, since the FIFO output is registered.
  - `i_halt` sampled in cycle N → `o_halted=1` and `o_insn_valid=0` in N+1.
- **Throughput:** 1 word/cycle when ack and ready are continuously high.
- **Full FIFO:** when `cnt==2`, `o_mem_req` is low. It is re-raised the cycle after a pop.
- **Priority:** reset > halt > redirect > ack/pop.

## Configuration
- **`FAVOR_FETCH_REDIRECT_EN` defined:**
  - `i_redirect`/`i_redirect_pc` exist. `i_redirect` high in RUN (and no halt):
    - FIFO flushed; any same-cycle ack discarded.
    - `pc <= {i_redirect_pc[ADDR_W-1:2], 2'b00}`.
    - `o_insn_valid=0` in the next cycle.
    - The next `o_mem_req` carries the new address in the next cycle.
  - Ignored in HALTED.
- **`FAVOR_FETCH_REDIRECT_EN` undefined:** ports and logic are absent; the PC only increments.

## Test plan
- **Reset then stream:** reset with `RESET_PC=0x100`; memory acks every cycle with data = address; ready high → `o_insn_pc` 0x100, 0x104, 0x108… on consecutive cycles, `o_insn` equal to `o_insn_pc`.
- **Backpressure:** ready low for 5 cycles → `cnt` reaches 2, `o_mem_req` drops; ready high → words pop in order with no loss or duplication.
- **Halt mid-stream:** `i_halt` pulses in the same cycle as an ack → next cycle `o_halted=1`, `o_insn_valid=0`, `o_insn=0xFFFF_FFFF`, no further `o_mem_req` for 20 cycles.
- **Slow memory:** ack delayed 3 cycles → `o_mem_addr` held stable for all 4 request cycles.
- **Wrap:** `ADDR_W=8`, `RESET_PC=0xFC` → fetch addresses 0xFC then 0x00.
- **Redirect (macro on):** redirect to 0x203 while the FIFO holds 2 words and an ack arrives → FIFO empty next cycle; next request address is 0x200.
